// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
//
// Shares one single-port unified memory between the instruction-fetch port
// (if_*) and the load/store data port (d_*) of mips_simple_cpu. One request is
// accepted per arbitration. The memory is strobed for exactly one cycle, and the
// owner gets rvalid MEM_LAT edges after the mem_en edge. The data port has
// priority. After STARVE_MAX consecutive contested data wins, fetch is forced.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-low reset
//   if_req/if_addr             fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata  fetch accept pulse, data-valid pulse, held data
//   d_req/d_we/d_addr/d_wdata  data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata     data accept pulse, load-valid/store-ack, held load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory side
//   busy                       high while an access is in flight
//
// Optional build macro MIPS_MEM_ARB_STATS_EN adds three 32-bit wrapping counters
// on extra outputs: if_grant_cnt, d_grant_cnt and stall_cnt.

module mips_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef MIPS_MEM_ARB_STATS_EN
    ,
    output logic [31:0]       if_grant_cnt,
    output logic [31:0]       d_grant_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [3:0] CntInit   = 4'(MEM_LAT - 1);
    localparam logic [3:0] StarveLim = 4'(STARVE_MAX);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        starve_q, starve_d;
    logic              owner_d_q, owner_d_d;   // 1 = data port owns the access
    logic              acc_we_q, acc_we_d;     // owner access was a store
    logic              if_gnt_q, if_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              pick_data;

    // Data wins unless fetch is also waiting and has been starved long enough.
    assign pick_data = d_req && !(if_req && (starve_q == StarveLim));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            starve_q    <= '0;
            owner_d_q   <= 1'b0;
            acc_we_q    <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            owner_d_q   <= owner_d_d;
            acc_we_q    <= acc_we_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        owner_d_d   = owner_d_q;
        acc_we_d    = acc_we_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (if_req || d_req) begin
                    state_d  = StAccess;
                    cnt_d    = CntInit;
                    mem_en_d = 1'b1;
                    if (pick_data) begin
                        owner_d_d   = 1'b1;
                        acc_we_d    = d_we;
                        d_gnt_d     = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        // Only contested data wins count toward starvation.
                        if (if_req && (starve_q != StarveLim)) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        owner_d_d   = 1'b0;
                        acc_we_d    = 1'b0;
                        if_gnt_d    = 1'b1;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        starve_d    = '0;
                    end
                end
            end
            StAccess: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StIdle;
                    if (owner_d_q) begin
                        d_rvalid_d = 1'b1;
                        // Stores only acknowledge; load data register is left alone.
                        if (!acc_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != StIdle);

`ifdef MIPS_MEM_ARB_STATS_EN
    logic [31:0] if_grant_cnt_q, d_grant_cnt_q, stall_cnt_q;

    // Stall: some request is pending during a cycle that carries no grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_grant_cnt_q <= '0;
            d_grant_cnt_q  <= '0;
            stall_cnt_q    <= '0;
        end else begin
            if (if_gnt_d) begin
                if_grant_cnt_q <= if_grant_cnt_q + 32'd1;
            end
            if (d_gnt_d) begin
                d_grant_cnt_q <= d_grant_cnt_q + 32'd1;
            end
            if ((if_req || d_req) && !(if_gnt_q || d_gnt_q)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign if_grant_cnt = if_grant_cnt_q;
    assign d_grant_cnt  = d_grant_cnt_q;
    assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter. Instance 0 runs with MEM_LAT=2 and
// instance 1 with MEM_LAT=1, both with STARVE_MAX=4. Stimulus pushes expected
// gnt/rvalid events into a queue; a monitor on the falling edge pops and
// compares each event the DUTs present, including the cycle gap to the previous
// event of the same instance.

module tb_mips_mem_arbiter;

    localparam int KIfGnt = 0;
    localparam int KDGnt  = 1;
    localparam int KIfRv  = 2;
    localparam int KDRv   = 3;

    typedef struct {
        int          inst;
        int          kind;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        int          delta;   // required cycles since previous event, -1 = any
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic        if_gnt    [2];
    logic        if_rvalid [2];
    logic [31:0] if_rdata  [2];
    logic        d_req     [2];
    logic        d_we      [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic        d_gnt     [2];
    logic        d_rvalid  [2];
    logic [31:0] d_rdata   [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];
`ifdef MIPS_MEM_ARB_STATS_EN
    logic [31:0] if_grant_cnt [2];
    logic [31:0] d_grant_cnt  [2];
    logic [31:0] stall_cnt    [2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mips_mem_arbiter #(
            .ADDR_W    (32),
            .DATA_W    (32),
            .MEM_LAT   ((g == 0) ? 2 : 1),
            .STARVE_MAX(4)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .if_req   (if_req[g]),
            .if_addr  (if_addr[g]),
            .if_gnt   (if_gnt[g]),
            .if_rvalid(if_rvalid[g]),
            .if_rdata (if_rdata[g]),
            .d_req    (d_req[g]),
            .d_we     (d_we[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_gnt    (d_gnt[g]),
            .d_rvalid (d_rvalid[g]),
            .d_rdata  (d_rdata[g]),
            .mem_en   (mem_en[g]),
            .mem_we   (mem_we[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]),
            .busy     (busy[g])
`ifdef MIPS_MEM_ARB_STATS_EN
            ,
            .if_grant_cnt(if_grant_cnt[g]),
            .d_grant_cnt (d_grant_cnt[g]),
            .stall_cnt   (stall_cnt[g])
`endif
        );
    end

    always #5 clk = ~clk;

    int  cyc = 0;
    int  n_total = 0;
    int  n_pass = 0;
    int  last_cyc [2];
    ev_t exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int inst, input int kind, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input int delta);
        ev_t e;
        e.inst  = inst;
        e.kind  = kind;
        e.we    = we;
        e.addr  = addr;
        e.data  = data;
        e.delta = delta;
        exp_q.push_back(e);
    endtask

    // Monitor: every asserted gnt/rvalid must match the next expected event.
    always @(negedge clk) begin
        ev_t  e;
        logic hit;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) begin
                case (k)
                    KIfGnt:  hit = if_gnt[i];
                    KDGnt:   hit = d_gnt[i];
                    KIfRv:   hit = if_rvalid[i];
                    default: hit = d_rvalid[i];
                endcase
                if (hit === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_event: inst %0d kind %0d at cycle %0d, required none",
                                 i, k, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_inst", 64'(i), 64'(e.inst));
                        chk("event_kind", 64'(k), 64'(e.kind));
                        if (e.delta >= 0) chk("event_spacing", 64'(cyc - last_cyc[i]), 64'(e.delta));
                        last_cyc[i] = cyc;
                        if (k == KIfGnt || k == KDGnt) begin
                            chk("gnt_mem_en", 64'(mem_en[i]), 64'd1);
                            chk("gnt_mem_we", 64'(mem_we[i]), 64'(e.we));
                            chk("gnt_mem_addr", 64'(mem_addr[i]), 64'(e.addr));
                            if (e.we) chk("gnt_mem_wdata", 64'(mem_wdata[i]), 64'(e.data));
                        end else if (k == KIfRv) begin
                            chk("if_rdata", 64'(if_rdata[i]), 64'(e.data));
                        end else begin
                            chk("d_rdata", 64'(d_rdata[i]), 64'(e.data));
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (busy[i] && n < 50) begin
            step();
            n++;
        end
        chk("idle_timeout", 64'(busy[i]), 64'd0);
    endtask

    // Single request on one port; drops it right after the grant pulse.
    task automatic do_req(input int i, input logic is_d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        int n = 0;
        if (is_d) begin
            d_req[i] = 1'b1; d_we[i] = we; d_addr[i] = addr; d_wdata[i] = wdata;
        end else begin
            if_req[i] = 1'b1; if_addr[i] = addr;
        end
        while (!(is_d ? d_gnt[i] : if_gnt[i]) && n < 50) begin
            step();
            n++;
        end
        chk("gnt_timeout", 64'(is_d ? d_gnt[i] : if_gnt[i]), 64'd1);
        d_req[i]  = 1'b0;
        if_req[i] = 1'b0;
    endtask

    initial begin
        int ngr;
`ifdef MIPS_MEM_ARB_STATS_EN
        logic [31:0] s_if, s_d, s_st;
`endif
        for (int i = 0; i < 2; i++) begin
            if_req[i] = 1'b0; if_addr[i] = '0; d_req[i] = 1'b0; d_we[i] = 1'b0;
            d_addr[i] = '0; d_wdata[i] = '0; mem_rdata[i] = '0; last_cyc[i] = 0;
        end
        step();
        step();
        reset = 1'b1;
        step();

        // Reset state
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", 64'(busy[i]), 64'd0);
            chk("rst_mem_en", 64'(mem_en[i]), 64'd0);
            chk("rst_if_rdata", 64'(if_rdata[i]), 64'd0);
            chk("rst_d_rdata", 64'(d_rdata[i]), 64'd0);
            chk("rst_mem_addr", 64'(mem_addr[i]), 64'd0);
        end

        // Fetch only
        mem_rdata[0] = 32'h2402000A;
        push(0, KIfGnt, 1'b0, 32'h100, 32'h0, -1);
        push(0, KIfRv, 1'b0, 32'h0, 32'h2402000A, 2);
        do_req(0, 1'b0, 1'b0, 32'h100, 32'h0);
        wait_idle(0);
        chk("fetch_d_rdata_untouched", 64'(d_rdata[0]), 64'd0);

        // Store then load; memory drives junk during the store
        mem_rdata[0] = 32'h11111111;
        push(0, KDGnt, 1'b1, 32'h40, 32'hDEADBEEF, -1);
        push(0, KDRv, 1'b0, 32'h0, 32'h0, 2);
        do_req(0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
        wait_idle(0);
        mem_rdata[0] = 32'hDEADBEEF;
        push(0, KDGnt, 1'b0, 32'h40, 32'h0, -1);
        push(0, KDRv, 1'b0, 32'h0, 32'hDEADBEEF, 2);
        do_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
        wait_idle(0);
        chk("load_if_rdata_held", 64'(if_rdata[0]), 64'h2402000A);

        // Contention: D,D,D,D,F,D,D,D,D,F with 3-cycle grant spacing
`ifdef MIPS_MEM_ARB_STATS_EN
        s_if = if_grant_cnt[0]; s_d = d_grant_cnt[0]; s_st = stall_cnt[0];
`endif
        mem_rdata[0] = 32'h0BADF00D;
        for (int g = 0; g < 10; g++) begin
            logic is_f;
            is_f = (g == 4) || (g == 9);
            push(0, is_f ? KIfGnt : KDGnt, 1'b0, is_f ? 32'h200 : 32'h300, 32'h0,
                 (g == 0) ? -1 : 1);
            push(0, is_f ? KIfRv : KDRv, 1'b0, 32'h0, 32'h0BADF00D, 2);
        end
        if_addr[0] = 32'h200; d_addr[0] = 32'h300; d_we[0] = 1'b0;
        if_req[0] = 1'b1; d_req[0] = 1'b1;
        ngr = 0;
        for (int n = 0; n < 200 && ngr < 10; n++) begin
            step();
            if (if_gnt[0] || d_gnt[0]) ngr++;
        end
        if_req[0] = 1'b0; d_req[0] = 1'b0;
        chk("contention_grants", 64'(ngr), 64'd10);
        wait_idle(0);
        step();
`ifdef MIPS_MEM_ARB_STATS_EN
        chk("stats_if_grants", 64'(if_grant_cnt[0] - s_if), 64'd2);
        chk("stats_d_grants", 64'(d_grant_cnt[0] - s_d), 64'd8);
        chk("stats_stalls", 64'(stall_cnt[0] - s_st), 64'd19);
`endif

        // Reset one cycle after mem_en aborts the access
        mem_rdata[0] = 32'h55555555;
        push(0, KIfGnt, 1'b0, 32'h500, 32'h0, -1);
        do_req(0, 1'b0, 1'b0, 32'h500, 32'h0);
        step();
        reset = 1'b0;
        #1;
        chk("abort_busy", 64'(busy[0]), 64'd0);
        chk("abort_mem_en", 64'(mem_en[0]), 64'd0);
        chk("abort_if_rvalid", 64'(if_rvalid[0]), 64'd0);
        chk("abort_d_rvalid", 64'(d_rvalid[0]), 64'd0);
        chk("abort_if_rdata", 64'(if_rdata[0]), 64'd0);
        step();
        step();
        reset = 1'b1;
        for (int n = 0; n < 5; n++) step();
        mem_rdata[0] = 32'h8C220004;
        push(0, KIfGnt, 1'b0, 32'h104, 32'h0, -1);
        push(0, KIfRv, 1'b0, 32'h0, 32'h8C220004, 2);
        do_req(0, 1'b0, 1'b0, 32'h104, 32'h0);
        wait_idle(0);

        // Back-to-back loads with MEM_LAT=1: d_gnt every 2 cycles
        mem_rdata[1] = 32'hCAFE0001;
        for (int g = 0; g < 4; g++) begin
            push(1, KDGnt, 1'b0, 32'h80, 32'h0, (g == 0) ? -1 : 1);
            push(1, KDRv, 1'b0, 32'h0, 32'hCAFE0001, 1);
        end
        d_addr[1] = 32'h80; d_we[1] = 1'b0; d_req[1] = 1'b1;
        ngr = 0;
        for (int n = 0; n < 100 && ngr < 4; n++) begin
            step();
            if (d_gnt[1]) ngr++;
        end
        d_req[1] = 1'b0;
        chk("b2b_grants", 64'(ngr), 64'd4);
        wait_idle(1);

        for (int n = 0; n < 4; n++) step();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares one single-port unified memory between the CPU instruction-fetch port and the load/store data port of mips_simple_cpu.
- Accepts one request per arbitration, drives the memory for exactly one cycle, waits a fixed memory latency, then returns read data or a write acknowledge to the owner.
- Data port has priority; a starvation guard guarantees forward progress for fetch.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, rising edges from the mem_en edge to the mem_rdata sample edge; legal range 1..15.
- STARVE_MAX, 4, consecutive contested data wins before fetch is forced; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; hold until if_gnt.
- if_addr  input  ADDR_W  fetch address.
- if_gnt  output  1  one-cycle accept pulse, fetch.
- if_rvalid  output  1  one-cycle fetch data valid.
- if_rdata  output  DATA_W  fetch data; holds last value.
- d_req  input  1  data request; hold until d_gnt.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_gnt  output  1  one-cycle accept pulse, data.
- d_rvalid  output  1  one-cycle load data valid or store ack.
- d_rdata  output  DATA_W  load data; holds last value and is unchanged by stores.
- mem_en  output  1  memory strobe, one cycle per access.
- mem_we  output  1  memory write enable, qualified by mem_en.
- mem_addr  output  ADDR_W  registered access address.
- mem_wdata  output  DATA_W  registered store data.
- mem_rdata  input  DATA_W  memory read data.
- busy  output  1  high while the arbiter is not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE; all outputs, latency counter, starve counter and owner are cleared to 0. Any access in flight is aborted and never produces rvalid.
- FSM states: IDLE and ACCESS.
- IDLE, no request: all strobes stay 0.
- IDLE, at an edge where a request is sampled:
  - Choose the owner.
  - Latch addr, we and wdata into mem_*.
  - Assert the owner's gnt and mem_en (mem_we = d_we if the owner is data, else 0) for exactly one cycle.
  - Load cnt = MEM_LAT-1 and go to ACCESS.
- Owner selection:
  - Only d_req set: data wins.
  - Only if_req set: fetch wins.
  - Both set: data wins unless starve == STARVE_MAX, in which case fetch wins.
- Starve counter:
  - Increments on each data grant made while if_req was also high.
  - Clears on any fetch grant.
  - Saturates at STARVE_MAX.
- ACCESS:
  - mem_en = 0 and requests are ignored.
  - While cnt != 0, decrement cnt.
  - At the edge where cnt == 0: capture mem_rdata into the owner's rdata (loads and fetches only), pulse the owner's rvalid for one cycle, and return to IDLE.
- Timing, with MEM_LAT = N:
  - Request sampled at edge E0 gives gnt/mem_en high for E0..E1.
  - rvalid is high for EN..EN+1.
  - The next grant is earliest at EN+1, so the spacing between grants is N+1 cycles.
- Requests are sampled only in IDLE. Dropping a request before its gnt is legal and causes no access. Inputs are not relatched after grant.
- gnt and rvalid are never high together on the same port. rvalid of one port never coincides with gnt of the other.

Optional Feature:
- Macro: MIPS_MEM_ARB_STATS_EN.
- Defined: adds three output ports, each 32 bits, cleared by reset and wrapping on overflow.
  - if_grant_cnt: count of fetch grants.
  - d_grant_cnt: count of data grants.
  - stall_cnt: +1 each cycle in which at least one request is high and no gnt is asserted.
- Undefined: these ports and their counters are absent. Core behaviour is identical.

Test Plan:
- Fetch only: MEM_LAT=2, if_addr=0x100, mem returns 0x2402000A. Required: if_gnt and mem_en with mem_addr=0x100 after E0; if_rvalid=1 with if_rdata=0x2402000A after E2; d_* outputs stay 0.
- Store then load: store to 0x40 with wdata 0xDEADBEEF, then load from 0x40 with mem returning 0xDEADBEEF.
  - Store: mem_we=1 and mem_wdata=0xDEADBEEF for one cycle; d_rvalid ack with d_rdata still 0.
  - Load: d_rdata=0xDEADBEEF.
- Contention: if_req and d_req held high for 10 grants, STARVE_MAX=4. Required grant order D,D,D,D,F,D,D,D,D,F; grants spaced 3 cycles apart.
- Reset mid-access: reset driven low one cycle after mem_en. Required: busy and all strobes 0 immediately and no rvalid ever for that access; after release, a new if_req is served normally.
- Back-to-back data requests with MEM_LAT=1: d_gnt pulses exactly every 2 cycles; d_rvalid follows each d_gnt by 1 edge.
- Stats, with MIPS_MEM_ARB_STATS_EN defined: after the contention scenario, if_grant_cnt=2 and d_grant_cnt=8; stall_cnt equals the number of non-gnt cycles with a request pending.
